aes_v3_col_seq: RTL and testbench



---
 rtl/aes_v3_col_seq.sv | 97 +++++++++
 tb/tb_aes_v3_col_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/aes_v3_col_seq.sv
// Column sequencer feeding the aes_v3_2 byte round-step unit: issues STEPS chained
// byte steps per job and returns the column. `AES_SEQ_ZEROIZE_EN clears operands after each job.
module aes_v3_col_seq #(
  parameter int STEPS = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dec,
  input  logic        req_mix,
  input  logic [31:0] req_s0,
  input  logic [31:0] req_s1,
  input  logic [31:0] req_s2,
  input  logic [31:0] req_s3,
  input  logic [31:0] req_key,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        aes_valid,
  output logic        aes_dec,
  output logic        aes_mix,
  output logic [31:0] aes_rs1,
  output logic [31:0] aes_rs2,
  output logic [1:0]  aes_bs,
  input  logic [31:0] aes_rd,
  input  logic        aes_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] LAST = 2'(STEPS - 1);

  state_t           state;
  logic [3:0][31:0] s;
  logic [31:0]      acc;
  logic [1:0]       cnt;

  // Step operands come straight off registers so they stay frozen across a stall.
  assign aes_rs2 = acc;
  assign aes_bs  = cnt;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      aes_valid <= 1'b0;
      aes_dec   <= 1'b0;
      aes_mix   <= 1'b0;
      aes_rs1   <= '0;
      s         <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          aes_dec   <= req_dec;
          aes_mix   <= req_mix;
          s         <= {req_s3, req_s2, req_s1, req_s0};
          acc       <= req_key;
          cnt       <= '0;
          aes_rs1   <= req_s0;
          aes_valid <= 1'b1;
          req_ready <= 1'b0;
          state     <= RUN;
        end
        RUN: if (aes_ready) begin
          acc <= aes_rd;
          if (cnt == LAST) begin
            aes_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rd    <= aes_rd;
            state     <= DONE;
          end else begin
            cnt     <= cnt + 2'd1;
            aes_rs1 <= s[cnt + 2'd1];
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
`ifdef AES_SEQ_ZEROIZE_EN
          s       <= '0;
          acc     <= '0;
          rsp_rd  <= '0;
          aes_rs1 <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_v3_col_seq.sv
// Directed bench for aes_v3_col_seq with a behavioural aes_v3_2 byte-step stub.
module tb_aes_v3_col_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_valid, req_ready, req_dec, req_mix;
  logic [31:0] req_s0, req_s1, req_s2, req_s3, req_key;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rd;
  logic        aes_valid, aes_dec, aes_mix;
  logic [31:0] aes_rs1, aes_rs2, aes_rd;
  logic [1:0]  aes_bs;
  logic        aes_ready;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  aes_v3_col_seq #(.STEPS(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec), .req_mix(req_mix),
    .req_s0(req_s0), .req_s1(req_s1), .req_s2(req_s2), .req_s3(req_s3), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .aes_valid(aes_valid), .aes_dec(aes_dec), .aes_mix(aes_mix),
    .aes_rs1(aes_rs1), .aes_rs2(aes_rs2), .aes_bs(aes_bs),
    .aes_rd(aes_rd), .aes_ready(aes_ready)
  );

  // Stub covers only the S-box entries the vectors use.
  function automatic logic [7:0] sb(input logic [7:0] x, input logic inv);
    if (!inv && x == 8'h00) return 8'h63;
    if (!inv && x == 8'h01) return 8'h7C;
    if (inv  && x == 8'h00) return 8'h52;
    return 8'h00;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] rs1, rs2, input logic [1:0] bs,
                                       input logic dec, mix);
    logic [7:0]  x, x2;
    logic [31:0] w;
    logic [63:0] ww;
    x  = sb(8'(rs1 >> (8 * bs)), dec);
    x2 = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    w  = (mix && !dec) ? {x2 ^ x, x, x, x2} : {24'h0, x};
    ww = {w, w} >> (32 - 8 * bs);
    return rs2 ^ ww[31:0];
  endfunction

  assign aes_rd = step(aes_rs1, aes_rs2, aes_bs, aes_dec, aes_mix);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One job: optional 3-cycle aes_ready stall on step stall_bs, optional rsp_ready hold.
  task automatic do_job(input string tag, input logic d, m, input logic [31:0] a, b, c, e, k,
                        input logic [31:0] exp, input int stall_bs, input int rsp_hold);
    int          cyc, stalls;
    logic [7:0]  bs_seq;
    logic [68:0] snap;
    bs_seq = '0; stalls = 0; cyc = 0; snap = '0;
    @(negedge g_clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_dec = d; req_mix = m;
    req_s0 = a; req_s1 = b; req_s2 = c; req_s3 = e; req_key = k;
    @(negedge g_clk);
    req_valid = 1'b0; cyc = 1;
    while (!rsp_valid && cyc < 50) begin
      if (aes_valid && int'(aes_bs) == stall_bs && stalls < 3) begin
        if (stalls == 0) snap = {aes_rs1, aes_rs2, aes_bs, aes_dec, aes_mix, 1'b0};
        else chk({tag, "_stall_hold"}, 32'({aes_rs1, aes_rs2, aes_bs, aes_dec, aes_mix, 1'b0} == snap), 32'd1);
        aes_ready = 1'b0;
        stalls++;
      end else begin
        aes_ready = 1'b1;
        if (aes_valid) bs_seq = {bs_seq[5:0], aes_bs};
      end
      @(negedge g_clk);
      cyc++;
    end
    aes_ready = 1'b1;
    chk({tag, "_latency"}, 32'(cyc), 32'(5 + stalls));
    chk({tag, "_rsp_rd"}, rsp_rd, exp);
    chk({tag, "_bs_seq"}, 32'(bs_seq), 32'h1B);
    for (int i = 0; i < rsp_hold; i++) begin
      req_valid = (i == 2);
      req_s0 = 32'hDEADBEEF;
      @(negedge g_clk);
      req_valid = 1'b0;
      chk({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rd"}, rsp_rd, exp);
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    chk({tag, "_back_idle"}, 32'({req_ready, rsp_valid, aes_valid}), 32'b100);
  endtask

  initial begin
    g_resetn = 1'b0; req_valid = 1'b0; req_dec = 1'b0; req_mix = 1'b0;
    req_s0 = '0; req_s1 = '0; req_s2 = '0; req_s3 = '0; req_key = '0;
    rsp_ready = 1'b0; aes_ready = 1'b1;
    repeat (2) @(negedge g_clk);
    chk("rst_flags", 32'({req_ready, rsp_valid, aes_valid}), 32'b100);
    chk("rst_rsp_rd", rsp_rd, 32'h0);
    chk("rst_rs1", aes_rs1, 32'h0);
    chk("rst_rs2", aes_rs2, 32'h0);
    chk("rst_bs", 32'(aes_bs), 32'h0);
    g_resetn = 1'b1;

    do_job("enc",     1'b0, 1'b0, 0, 0, 0, 0, 32'h0,        32'h63636363, -1, 0);
    do_job("encmix",  1'b0, 1'b1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h9C9C9C9C, -1, 0);
    do_job("dec",     1'b1, 1'b0, 0, 0, 0, 0, 32'h0,        32'h52525252, -1, 0);
    do_job("enc_s0",  1'b0, 1'b0, 1, 0, 0, 0, 32'h0,        32'h6363637C, -1, 0);
    do_job("stall",   1'b0, 1'b0, 0, 0, 0, 0, 32'h0,        32'h63636363,  1, 0);
    do_job("rsphold", 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,        32'h63636363, -1, 5);

    // Step-0 result of the mix vector, checked directly on the stub port.
    @(negedge g_clk);
    req_valid = 1'b1; req_dec = 1'b0; req_mix = 1'b1;
    req_s0 = '0; req_s1 = '0; req_s2 = '0; req_s3 = '0; req_key = 32'hFFFFFFFF;
    @(negedge g_clk);
    req_valid = 1'b0;
    chk("mix_step0_rd", aes_rd, 32'h5A9C9C39);
    @(negedge g_clk);
    chk("mix_step1_rs2", aes_rs2, 32'h5A9C9C39);
    @(negedge g_clk);
    chk("rst_mid_bs", 32'(aes_bs), 32'd2);
    g_resetn = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    chk("rst_mid_flags", 32'({req_ready, rsp_valid, aes_valid}), 32'b100);
    chk("rst_mid_rd", rsp_rd, 32'h0);
    do_job("after_rst", 1'b0, 1'b0, 1, 0, 0, 0, 32'h0, 32'h6363637C, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
